// File: rtl/vram_access_arbiter.sv
// VRAM port arbiter: video fetch has priority, timed from the character-cell phase.
// The CPU is held off with cpu_wait until its single access completes.
module vram_access_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int CPU_LAST = 12
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              show_pixel,
  input  logic [3:0]        subchar_pixel,
  input  logic [ADDR_W-1:0] video_addr,
  output logic [DATA_W-1:0] video_data,
  output logic              video_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    IDLE, V_RD, V_LAT, C_RD, C_LAT, C_WR
  } state_t;

  localparam logic [3:0] CpuLast = 4'(CPU_LAST);

  state_t            state;
  logic              vid_pend;
  logic              done;
  logic [ADDR_W-1:0] vid_addr_q;

  logic trigger;
  logic cpu_window;
  logic decide;
  logic cpu_slot;
  logic go_vid;
  logic go_cpu;

  assign trigger    = show_pixel & (subchar_pixel == 4'd0);
  assign cpu_window = ~show_pixel | (subchar_pixel <= CpuLast);
  assign cpu_wait   = cpu_req & ~done;

  // Terminal states may chain straight into the next access;
  // a CPU access never chains into another CPU access.
  always_comb begin
    decide   = 1'b0;
    cpu_slot = 1'b0;
    unique case (1'b1)
      (state == IDLE), (state == V_LAT): begin
        decide   = 1'b1;
        cpu_slot = 1'b1;
      end
      (state == C_LAT), (state == C_WR): decide = 1'b1;
      default: ;
    endcase
    go_vid = decide & (vid_pend | trigger);
    go_cpu = cpu_slot & ~go_vid & cpu_req & ~done
           & ~vid_pend & ~trigger & cpu_window;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state       <= IDLE;
      vid_pend    <= 1'b0;
      done        <= 1'b0;
      vid_addr_q  <= '0;
      video_data  <= '0;
      video_valid <= 1'b0;
      cpu_rdata   <= '0;
      cpu_ack     <= 1'b0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
    end else begin
      video_valid <= 1'b0;
      cpu_ack     <= 1'b0;
      ram_we      <= 1'b0;
      if (trigger) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= video_addr;
      end
      if (!cpu_req) done <= 1'b0;
      unique case (state)
        V_RD:  state <= V_LAT;
        C_RD:  state <= C_LAT;
        V_LAT: begin
          video_valid <= 1'b1;
          video_data  <= ram_rdata;
        end
        C_LAT: begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= ram_rdata;
          done      <= 1'b1;
        end
        C_WR: begin
          cpu_ack <= 1'b1;
          done    <= 1'b1;
        end
        default: ;
      endcase
      if (decide) begin
        if (go_vid) begin
          state    <= V_RD;
          vid_pend <= 1'b0;
          ram_addr <= trigger ? video_addr : vid_addr_q;
        end else if (go_cpu) begin
          state    <= cpu_we ? C_WR : C_RD;
          ram_addr <= cpu_addr;
          ram_we   <= cpu_we;
          if (cpu_we) ram_wdata <= cpu_wdata;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter with a behavioural
// synchronous VRAM (one-cycle registered read).
module tb_vram_access_arbiter;

  logic        pixel_clock;
  logic        reset;
  logic        show_pixel;
  logic [3:0]  subchar_pixel;
  logic [12:0] video_addr;
  logic [7:0]  video_data;
  logic        video_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem [0:8191];

  int checks = 0;
  int errors = 0;

  vram_access_arbiter dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .show_pixel   (show_pixel),
    .subchar_pixel(subchar_pixel),
    .video_addr   (video_addr),
    .video_data   (video_data),
    .video_valid  (video_valid),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cpu_wait     (cpu_wait),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial pixel_clock = 1'b0;
  always #5 pixel_clock = ~pixel_clock;

  always @(posedge pixel_clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // One edge; inputs move and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge pixel_clock);
    #1;
    subchar_pixel = subchar_pixel + 4'd1;
  endtask

  task automatic goto_phase(input logic [3:0] ph);
    for (int i = 0; i < 16; i++) begin
      if (subchar_pixel == ph) break;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (video_valid !== 1'b0 || cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_strobes got %b%b%b exp 000",
               video_valid, cpu_ack, ram_we);
    end
    checks++;
    if (ram_addr !== 13'h0 || ram_wdata !== 8'h0) begin
      errors++;
      $display("FAIL rst_ram got %h/%h exp 0/0", ram_addr, ram_wdata);
    end
    checks++;
    if (video_data !== 8'h0 || cpu_rdata !== 8'h0 || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL rst_data got %h/%h/%b exp 0/0/0",
               video_data, cpu_rdata, cpu_wait);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic cpu_write(input logic [12:0] a, input logic [7:0] d,
                           input string nm);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    #1;
    checks++;
    if (cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait got %b exp 1", nm, cpu_wait);
    end
    tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== a || ram_wdata !== d || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL %s_grant got we%b a%h d%h ack%b exp we1 a%h d%h ack0",
               nm, ram_we, ram_addr, ram_wdata, cpu_ack, a, d);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || ram_we !== 1'b0 || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack got ack%b we%b wait%b exp ack1 we0 wait0",
               nm, cpu_ack, ram_we, cpu_wait);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_cpu_write_read();
    show_pixel = 1'b0;
    cpu_write(13'h0040, 8'h7F, "wr40");
    cpu_write(13'h0123, 8'hA5, "wr123");
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040;
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_early_ack got %b exp 0", cpu_ack);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h7F) begin
      errors++;
      $display("FAIL rd_ack got ack%b d%h exp ack1 d7f", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_rdata !== 8'h7F || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_hold got d%h ack%b exp d7f ack0", cpu_rdata, cpu_ack);
    end
  endtask

  task automatic test_video_sweep();
    int nvalid;
    logic exp_v;
    nvalid = 0;
    goto_phase(4'd15);
    video_addr = 13'h0123;
    show_pixel = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_v = (subchar_pixel == 4'd3);
      checks++;
      if (video_valid !== exp_v) begin
        errors++;
        $display("FAIL vid_valid_ph%0d got %b exp %b",
                 subchar_pixel, video_valid, exp_v);
      end
      if (video_valid === 1'b1) begin
        nvalid++;
        checks++;
        if (video_data !== 8'hA5) begin
          errors++;
          $display("FAIL vid_data got %h exp a5", video_data);
        end
      end
    end
    checks++;
    if (nvalid != 2) begin
      errors++;
      $display("FAIL vid_count got %0d exp 2", nvalid);
    end
  endtask

  task automatic test_cpu_blocked();
    int gph;
    int aph;
    logic [7:0] rd;
    logic vv;
    gph = -1; aph = -1; rd = 8'h00; vv = 1'b0;
    goto_phase(4'd13);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0040;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (cpu_ack === 1'b1) begin
        aph = int'(subchar_pixel);
        rd = cpu_rdata;
        break;
      end
      checks++;
      if (cpu_wait !== 1'b1) begin
        errors++;
        $display("FAIL blk_wait_ph%0d got %b exp 1", subchar_pixel, cpu_wait);
      end
      if (gph < 0 && ram_addr === 13'h0040) begin
        gph = int'(subchar_pixel);
        vv = video_valid;
      end
      tick();
    end
    checks++;
    if (gph != 3 || vv !== 1'b1) begin
      errors++;
      $display("FAIL blk_grant got ph%0d vv%b exp ph3 vv1", gph, vv);
    end
    checks++;
    if (aph != 5 || rd !== 8'h7F) begin
      errors++;
      $display("FAIL blk_ack got ph%0d d%h exp ph5 d7f", aph, rd);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    goto_phase(4'd0);
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 13'h0050; cpu_wdata = 8'h3C;
    tick();
    checks++;
    if (ram_we !== 1'b0 || ram_addr !== 13'h0123) begin
      errors++;
      $display("FAIL same_vrd got we%b a%h exp we0 a0123", ram_we, ram_addr);
    end
    tick();
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL same_vlat got we%b exp 0", ram_we);
    end
    tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 13'h0050 ||
        video_valid !== 1'b1 || video_data !== 8'hA5) begin
      errors++;
      $display("FAIL same_grant got we%b a%h vv%b vd%h exp we1 a0050 vv1 vda5",
               ram_we, ram_addr, video_valid, video_data);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || ram_we !== 1'b0 || mem[13'h0050] !== 8'h3C) begin
      errors++;
      $display("FAIL same_ack got ack%b we%b m%h exp ack1 we0 m3c",
               cpu_ack, ram_we, mem[13'h0050]);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int nack;
    int nwe;
    nack = 0; nwe = 0;
    show_pixel = 1'b0;
    tick();
    tick();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 13'h0060; cpu_wdata = 8'h11;
    for (int i = 0; i < 44; i++) begin
      tick();
      if (cpu_ack === 1'b1) nack++;
      if (ram_we === 1'b1) nwe++;
    end
    checks++;
    if (nack != 1 || nwe != 1 || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL held_once got ack%0d we%0d wait%b exp 1 1 0",
               nack, nwe, cpu_wait);
    end
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0;
    #1;
    checks++;
    if (cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL held_rearm got %b exp 1", cpu_wait);
    end
    nack = 0;
    tick();
    if (cpu_ack === 1'b1) nack++;
    tick();
    if (cpu_ack === 1'b1) nack++;
    tick();
    checks++;
    if (nack != 0 || cpu_ack !== 1'b1 || cpu_rdata !== 8'h11) begin
      errors++;
      $display("FAIL held_second got early%0d ack%b d%h exp 0 1 11",
               nack, cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 13'h0070; cpu_wdata = 8'h99;
    tick();
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL rstw_grant got %b exp 1", ram_we);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ram_we !== 1'b0 || cpu_ack !== 1'b0 || cpu_wait !== 1'b1) begin
      errors++;
      $display("FAIL rstw_abort got we%b ack%b wait%b exp 0 0 1",
               ram_we, cpu_ack, cpu_wait);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rstw_hold got ack%b we%b exp 0 0", cpu_ack, ram_we);
    end
    cpu_req = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || ram_we !== 1'b0 || cpu_wait !== 1'b0) begin
      errors++;
      $display("FAIL rstw_idle got ack%b we%b wait%b exp 0 0 0",
               cpu_ack, ram_we, cpu_wait);
    end
  endtask

  initial begin
    reset = 1'b1;
    show_pixel = 1'b0;
    subchar_pixel = 4'd0;
    video_addr = 13'h0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = 13'h0;
    cpu_wdata = 8'h0;
    test_reset();
    test_cpu_write_read();
    test_video_sweep();
    test_cpu_blocked();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
